// File: rtl/uart_result_framer_pkg.sv
// Shared types and frame constants for the UART result framer.
// Frame layout: HEADER, LEN (=n+1), CMD_RESULT, payload, FOOTER.
package Definitions;

  localparam logic [7:0] HEADER     = 8'hFE;
  localparam logic [7:0] CMD_RESULT = 8'h05;
  localparam logic [7:0] FOOTER     = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_CMD,
    ST_POP,
    ST_LATCH,
    ST_DATA,
    ST_FTR
  } frame_state_t;

  typedef enum logic [1:0] {
    HS_ISSUE,
    HS_WAIT_LOW,
    HS_WAIT_HIGH
  } hs_state_t;

endpackage

// File: rtl/uart_result_framer_handshake.sv
// Sends one byte to the UART transmitter and waits for it to complete.
// state        | meaning
// HS_ISSUE     | wait for tx_ready, then strobe tx_send with the byte
// HS_WAIT_LOW  | wait for the UART to report busy (tx_ready low)
// HS_WAIT_HIGH | wait for the UART to go idle again; byte_done
module uart_tx_byte_handshake
  import Definitions::*;
#(
  parameter int WORD_LENGHT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [WORD_LENGHT-1:0] byte_in,
  input  logic                   tx_ready,
  output logic                   tx_send,
  output logic [WORD_LENGHT-1:0] tx_data,
  output logic                   byte_done
);

  hs_state_t state, state_nxt;
  logic [WORD_LENGHT-1:0] data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= HS_ISSUE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HS_ISSUE:     if (go && tx_ready) state_nxt = HS_WAIT_LOW;
      HS_WAIT_LOW:  if (!tx_ready)      state_nxt = HS_WAIT_HIGH;
      HS_WAIT_HIGH: if (tx_ready)       state_nxt = HS_ISSUE;
      default:                          state_nxt = HS_ISSUE;
    endcase
  end

  // tx_data shows the new byte in the issue cycle itself, then the held copy
  always_comb begin
    tx_send   = (state == HS_ISSUE) && go && tx_ready;
    byte_done = (state == HS_WAIT_HIGH) && tx_ready;
    tx_data   = tx_send ? byte_in : data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       data_q <= '0;
    else if (tx_send) data_q <= byte_in;
  end

endmodule

// File: rtl/uart_result_framer.sv
// Pops n result bytes from the output FIFO and sends them as one framed
// packet over the UART byte handshake.
// state    | meaning
// ST_IDLE  | waiting for start; n latched on accept
// ST_HDR   | sending HEADER
// ST_LEN   | sending n+1
// ST_CMD   | sending CMD_RESULT
// ST_POP   | pop one FIFO byte (stall while empty)
// ST_LATCH | capture popped FIFO data
// ST_DATA  | sending payload byte
// ST_FTR   | sending FOOTER; done when it completes
module uart_result_framer
  import Definitions::*;
#(
  parameter int                   WORD_LENGHT = 8,
  parameter logic [WORD_LENGHT-1:0] HDR_BYTE  = Definitions::HEADER,
  parameter logic [WORD_LENGHT-1:0] CMD_BYTE  = Definitions::CMD_RESULT,
  parameter logic [WORD_LENGHT-1:0] FTR_BYTE  = Definitions::FOOTER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             n,
  input  logic [WORD_LENGHT-1:0] fifo_data,
  input  logic                   fifo_empty,
  output logic                   fifo_pop,
  input  logic                   tx_ready,
  output logic                   tx_send,
  output logic [WORD_LENGHT-1:0] tx_data,
  output logic                   busy,
  output logic                   done
);

  frame_state_t state, state_nxt;
  logic [3:0]             count_q;
  logic [WORD_LENGHT-1:0] data_q;
  logic [WORD_LENGHT-1:0] byte_sel;
  logic [WORD_LENGHT-1:0] len_byte;
  logic                   go;
  logic                   byte_done;

  assign len_byte = WORD_LENGHT'(count_q) + WORD_LENGHT'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start)      state_nxt = ST_HDR;
      ST_HDR:   if (byte_done)  state_nxt = ST_LEN;
      ST_LEN:   if (byte_done)  state_nxt = ST_CMD;
      ST_CMD:   if (byte_done)  state_nxt = (count_q == 4'd0) ? ST_FTR : ST_POP;
      ST_POP:   if (!fifo_empty) state_nxt = ST_LATCH;
      ST_LATCH:                 state_nxt = ST_DATA;
      ST_DATA:  if (byte_done)  state_nxt = (count_q == 4'd1) ? ST_FTR : ST_POP;
      ST_FTR:   if (byte_done)  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    go       = 1'b0;
    byte_sel = '0;
    case (state)
      ST_HDR:  begin go = 1'b1; byte_sel = HDR_BYTE; end
      ST_LEN:  begin go = 1'b1; byte_sel = len_byte; end
      ST_CMD:  begin go = 1'b1; byte_sel = CMD_BYTE; end
      ST_DATA: begin go = 1'b1; byte_sel = data_q;   end
      ST_FTR:  begin go = 1'b1; byte_sel = FTR_BYTE; end
      default: ;
    endcase
    fifo_pop = (state == ST_POP) && !fifo_empty;
    busy     = (state != ST_IDLE);
    done     = (state == ST_FTR) && byte_done;
  end

  // count holds the payload bytes still to send; it equals n while in LEN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
      data_q  <= '0;
    end else begin
      if (state == ST_IDLE && start)
        count_q <= n;
      else if (state == ST_DATA && byte_done)
        count_q <= count_q - 4'd1;
      if (state == ST_LATCH)
        data_q <= fifo_data;
    end
  end

  uart_tx_byte_handshake #(
    .WORD_LENGHT (WORD_LENGHT)
  ) u_handshake (
    .clk       (clk),
    .reset     (reset),
    .go        (go),
    .byte_in   (byte_sel),
    .tx_ready  (tx_ready),
    .tx_send   (tx_send),
    .tx_data   (tx_data),
    .byte_done (byte_done)
  );

endmodule
